// File: rtl/dmem_access_unit_if.sv
// Request/response bundle between the EX/MEM register and the MEM-stage data memory.
// The master side is the pipeline; the slave side is dmem_access_unit.
interface dmem_access_unit_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            funct3;
    logic                  stall;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  access_fault;

    modport master (
        output mem_read, mem_write, addr, wr_data, funct3,
        input  stall, rd_data, rd_valid, access_fault
    );

    modport slave (
        input  mem_read, mem_write, addr, wr_data, funct3,
        output stall, rd_data, rd_valid, access_fault
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory: RISC-V B/H/W loads and stores on a little-endian word array,
// with multi-cycle load latency (pipeline stall) and misalignment/illegal-op fault pulses.
module dmem_access_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_access_unit_if.slave bus
);
    localparam int         WORDS  = 2 ** (DM_ADDRESS - 2);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LAT_M1  = 4'(RD_LAT - 1);

    logic [DATA_W-1:0]     mem_r [0:WORDS-1];
    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic [DATA_W-1:0]     lat_word_r;
    logic [2:0]            lat_f3_r;
    logic [1:0]            lat_off_r;
    logic [DATA_W-1:0]     rd_data_r;
    logic                  rd_valid_r;

    logic [DM_ADDRESS-3:0] word_idx_s;
    logic [DATA_W-1:0]     rd_word_s;
    logic                  fault_s;
    logic                  idle_s;
    logic                  load_acc_s;
    logic                  store_acc_s;
    logic [3:0]            be_s;
    logic [DATA_W-1:0]     wdata_s;

    // Lane extraction with sign/zero extension; unknown codes never reach here (faulted).
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [4:0]  sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        sh = {off, 3'b000};
        b  = w[sh +: 8];
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            default: res = w;
        endcase
        return res;
    endfunction

    assign word_idx_s = bus.addr[DM_ADDRESS-1:2];
    assign rd_word_s  = mem_r[word_idx_s];

    // Fault classification of the request currently presented.
    always_comb begin
        fault_s = 1'b0;
        if (bus.mem_read && bus.mem_write) begin
            fault_s = 1'b1;
        end else if (bus.mem_read) begin
            case (bus.funct3)
                3'b000, 3'b100: fault_s = 1'b0;
                3'b001, 3'b101: fault_s = bus.addr[0];
                3'b010:         fault_s = (bus.addr[1:0] != 2'b00);
                default:        fault_s = 1'b1;
            endcase
        end else if (bus.mem_write) begin
            case (bus.funct3)
                3'b000:  fault_s = 1'b0;
                3'b001:  fault_s = bus.addr[0];
                3'b010:  fault_s = (bus.addr[1:0] != 2'b00);
                default: fault_s = 1'b1;
            endcase
        end else begin
            fault_s = 1'b0;
        end
    end

    // Requests are only looked at in IDLE and never while reset is asserted.
    assign idle_s      = reset && (state_r == ST_IDLE);
    assign load_acc_s  = idle_s && bus.mem_read && !fault_s;
    assign store_acc_s = idle_s && bus.mem_write && !fault_s;

    // Byte-lane enables and replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = bus.wr_data;
        case (bus.funct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << bus.addr[1:0];
                wdata_s = {4{bus.wr_data[7:0]}};
            end
            2'b01: begin
                be_s    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{bus.wr_data[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = bus.wr_data;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = bus.wr_data;
            end
        endcase
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_acc_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Load FSM: latch at acceptance, count down the latency, present the result for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            lat_word_r <= 32'h0000_0000;
            lat_f3_r   <= 3'b000;
            lat_off_r  <= 2'b00;
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_acc_s) begin
                        lat_word_r <= rd_word_s;
                        lat_f3_r   <= bus.funct3;
                        lat_off_r  <= bus.addr[1:0];
                        cnt_r      <= LAT_M1;
                        if (RD_LAT > 1) begin
                            state_r <= ST_WAIT;
                        end else begin
                            state_r    <= ST_DONE;
                            rd_valid_r <= 1'b1;
                            rd_data_r  <= load_extract(rd_word_s, bus.funct3, bus.addr[1:0]);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r    <= ST_DONE;
                        rd_valid_r <= 1'b1;
                        rd_data_r  <= load_extract(lat_word_r, lat_f3_r, lat_off_r);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // The request cycle stall and fault pulse must be seen by the pipeline in the same cycle.
    assign bus.stall        = reset && (load_acc_s || (state_r == ST_WAIT));
    assign bus.access_fault = idle_s && (bus.mem_read || bus.mem_write) && fault_s;
    assign bus.rd_data      = rd_data_r;
    assign bus.rd_valid     = rd_valid_r;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: three instances (RD_LAT = 2, 4, 1) share the
// stimulus; sel routes requests to one instance and its outputs back to the checks.
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  funct3;
    int          sel;
    logic        stall, rd_valid, access_fault;
    logic [31:0] rd_data;
    int          n_checks = 0;
    int          n_errors = 0;
    int          rv_count = 0;
    int          rv_before;

    always #5 clk = ~clk;

    dmem_access_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) if_l2 ();
    dmem_access_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) if_l4 ();
    dmem_access_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) if_l1 ();

    dmem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(2)) u_dut_l2 (.clk(clk), .reset(reset), .bus(if_l2));
    dmem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(4)) u_dut_l4 (.clk(clk), .reset(reset), .bus(if_l4));
    dmem_access_unit #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(if_l1));

    assign if_l2.mem_read  = mem_read  && (sel == 0);
    assign if_l2.mem_write = mem_write && (sel == 0);
    assign if_l4.mem_read  = mem_read  && (sel == 1);
    assign if_l4.mem_write = mem_write && (sel == 1);
    assign if_l1.mem_read  = mem_read  && (sel == 2);
    assign if_l1.mem_write = mem_write && (sel == 2);
    assign if_l2.addr = addr;  assign if_l2.wr_data = wr_data;  assign if_l2.funct3 = funct3;
    assign if_l4.addr = addr;  assign if_l4.wr_data = wr_data;  assign if_l4.funct3 = funct3;
    assign if_l1.addr = addr;  assign if_l1.wr_data = wr_data;  assign if_l1.funct3 = funct3;

    always_comb begin
        case (sel)
            1: begin
                stall = if_l4.stall; rd_valid = if_l4.rd_valid;
                access_fault = if_l4.access_fault; rd_data = if_l4.rd_data;
            end
            2: begin
                stall = if_l1.stall; rd_valid = if_l1.rd_valid;
                access_fault = if_l1.access_fault; rd_data = if_l1.rd_data;
            end
            default: begin
                stall = if_l2.stall; rd_valid = if_l2.rd_valid;
                access_fault = if_l2.access_fault; rd_data = if_l2.rd_data;
            end
        endcase
    end

    always @(posedge clk) begin
        if (rd_valid) rv_count <= rv_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d);
        mem_read = r; mem_write = w; funct3 = f3; addr = a; wr_data = d;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d,
                            input logic exp_fault);
        drive(1'b0, 1'b1, f3, a, d);
        @(negedge clk);
        check_val("st_fault", {31'd0, access_fault}, {31'd0, exp_fault});
        check_val("st_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    endtask

    // Leaves mem_read asserted after DONE; the caller issues the next request or idles.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [8:0] a,
                           input logic [31:0] exp, input int lat);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check_val({tag, "_stall"}, {31'd0, stall}, 32'd1);
            check_val({tag, "_early_rv"}, {31'd0, rd_valid}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check_val({tag, "_rv"}, {31'd0, rd_valid}, 32'd1);
        check_val({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        check_val({tag, "_data"}, rd_data, exp);
        next_cycle();
    endtask

    task automatic fault_req(input string tag, input logic r, input logic w,
                             input logic [2:0] f3, input logic [8:0] a);
        drive(r, w, f3, a, 32'h5555_5555);
        @(negedge clk);
        check_val({tag, "_af"}, {31'd0, access_fault}, 32'd1);
        check_val({tag, "_stall"}, {31'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        @(negedge clk);
        check_val({tag, "_rv"}, {31'd0, rd_valid}, 32'd0);
        check_val({tag, "_af_clr"}, {31'd0, access_fault}, 32'd0);
        next_cycle();
    endtask

    initial begin
        sel   = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        #12;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_rv", {31'd0, rd_valid}, 32'd0);
        check_val("rst_rdata", rd_data, 32'h0);
        check_val("rst_af", {31'd0, access_fault}, 32'd0);
        drive(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
        #1;
        check_val("rst_req_stall", {31'd0, stall}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        // RD_LAT = 2 instance
        do_store(3'b010, 9'h010, 32'hDEAD_BEEF, 1'b0);
        do_load("lw10", 3'b010, 9'h010, 32'hDEAD_BEEF, 2);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        @(negedge clk);
        check_val("hold_rv", {31'd0, rd_valid}, 32'd0);
        check_val("hold_rdata", rd_data, 32'hDEAD_BEEF);
        next_cycle();

        do_store(3'b010, 9'h020, 32'h1122_3344, 1'b0);
        do_store(3'b000, 9'h021, 32'h0000_00AA, 1'b0);
        do_load("lw20", 3'b010, 9'h020, 32'h1122_AA44, 2);
        do_store(3'b001, 9'h022, 32'h0000_BEEF, 1'b0);
        do_load("lw20b", 3'b010, 9'h020, 32'hBEEF_AA44, 2);

        do_store(3'b010, 9'h040, 32'h8001_F0FF, 1'b0);
        do_load("lb40", 3'b000, 9'h040, 32'hFFFF_FFFF, 2);
        do_load("lbu40", 3'b100, 9'h040, 32'h0000_00FF, 2);
        do_load("lh42", 3'b001, 9'h042, 32'hFFFF_8001, 2);
        do_load("lhu42", 3'b101, 9'h042, 32'h0000_8001, 2);
        do_load("lh40", 3'b001, 9'h040, 32'hFFFF_F0FF, 2);
        do_load("lb41", 3'b000, 9'h041, 32'hFFFF_FFF0, 2);
        do_load("lbu43", 3'b100, 9'h043, 32'h0000_0080, 2);

        fault_req("f_lw41", 1'b1, 1'b0, 3'b010, 9'h041);
        fault_req("f_sh43", 1'b0, 1'b1, 3'b001, 9'h043);
        fault_req("f_rw", 1'b1, 1'b1, 3'b010, 9'h040);
        fault_req("f_ld011", 1'b1, 1'b0, 3'b011, 9'h040);
        fault_req("f_st100", 1'b0, 1'b1, 3'b100, 9'h040);
        do_load("lw40_after", 3'b010, 9'h040, 32'h8001_F0FF, 2);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        next_cycle();

        // RD_LAT = 4 instance, reset during the second WAIT cycle
        sel = 1;
        do_store(3'b010, 9'h080, 32'h0F0F_1234, 1'b0);
        rv_before = rv_count;
        drive(1'b1, 1'b0, 3'b010, 9'h080, 32'h0);
        @(negedge clk);
        check_val("ml_req_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        check_val("ml_rst_stall", {31'd0, stall}, 32'd0);
        check_val("ml_rst_rv", {31'd0, rd_valid}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        check_val("ml_no_pulse", rv_count - rv_before, 32'd0);
        do_load("ml_fresh", 3'b010, 9'h080, 32'h0F0F_1234, 4);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        next_cycle();

        // RD_LAT = 1 instance, back-to-back loads with mem_read held through DONE
        sel = 2;
        do_store(3'b010, 9'h100, 32'h1234_5678, 1'b0);
        do_store(3'b010, 9'h104, 32'hCAFE_F00D, 1'b0);
        rv_before = rv_count;
        do_load("b2b_a", 3'b010, 9'h100, 32'h1234_5678, 1);
        do_load("b2b_b", 3'b010, 9'h104, 32'hCAFE_F00D, 1);
        drive(1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        @(negedge clk);
        check_val("b2b_rv_clr", {31'd0, rd_valid}, 32'd0);
        next_cycle();
        check_val("b2b_pulses", rv_count - rv_before, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
